// File: rtl/cla8_share_sched.sv
// Byte-serial add/sub engine sharing one external 8-bit CLA slice among NREQ requesters.
// Round-robin grant in IDLE, one byte per cycle in RUN, result held in DONE until taken.
module cla8_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_ovf,
  output logic [7:0]              add_a,
  output logic [7:0]              add_b,
  output logic                    add_cin,
  input  logic [7:0]              add_s,
  input  logic                    add_cout
);
  localparam int BYTES = WIDTH / 8;
  localparam int IDW   = $clog2(NREQ);
  localparam int KW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IDW-1:0]   id;
  } op_t;

  state_t state, state_nxt;
  op_t    op;
  logic [KW-1:0]                 k;
  logic [IDW-1:0]                ptr, gnt_id, hi_id, lo_id;
  logic                          gnt_hit, hi_hit, lo_hit, carry, last_byte;
  logic [NREQ-1:0][WIDTH-1:0]    a_arr, b_arr;
  logic [BYTES-1:0][7:0]         opa_b, opb_b, result, res_nxt;

  assign a_arr     = req_a;
  assign b_arr     = req_b;
  assign opa_b     = op.a;
  assign opb_b     = op.b;
  assign last_byte = (k == KW'(BYTES - 1));
  assign rsp_valid = (state == DONE);

  // Round robin: lowest valid index above ptr wins, else lowest at or below ptr.
  always_comb begin
    hi_hit = 1'b0;
    hi_id  = '0;
    lo_hit = 1'b0;
    lo_id  = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        if (IDW'(j) > ptr) begin
          hi_hit = 1'b1;
          hi_id  = IDW'(j);
        end else begin
          lo_hit = 1'b1;
          lo_id  = IDW'(j);
        end
      end
    end
    gnt_hit = hi_hit | lo_hit;
    gnt_id  = hi_hit ? hi_id : lo_id;
  end

  always_comb begin
    res_nxt    = result;
    res_nxt[k] = add_s;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: if (gnt_hit && !rst) begin
        req_ready[gnt_id] = 1'b1;
        state_nxt         = RUN;
      end
      RUN: begin
        add_a   = opa_b[k];
        add_b   = opb_b[k];
        add_cin = carry;
        if (last_byte) state_nxt = DONE;
      end
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // rsp_* are loaded only on the last byte so they stay put through later ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      k        <= '0;
      ptr      <= IDW'(NREQ - 1);
      carry    <= 1'b0;
      result   <= '0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_hit) begin
          op.a  <= a_arr[gnt_id];
          op.b  <= req_sub[gnt_id] ? ~b_arr[gnt_id] : b_arr[gnt_id];
          op.id <= gnt_id;
          carry <= req_sub[gnt_id];
          ptr   <= gnt_id;
          k     <= '0;
        end
        RUN: begin
          result <= res_nxt;
          carry  <= add_cout;
          k      <= last_byte ? '0 : k + KW'(1);
          if (last_byte) begin
            rsp_sum  <= res_nxt;
            rsp_cout <= add_cout;
            rsp_id   <= op.id;
            rsp_ovf  <= (op.a[MSB] == op.b[MSB]) & (res_nxt[BYTES-1][7] != op.a[MSB]);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla8_share_sched.sv
// Bench for cla8_share_sched: arithmetic/round-robin reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_cla8_share_sched;
  localparam int NREQ = 4, WIDTH = 16, BYTES = WIDTH / 8;

  logic                  clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0, req_sub = '0, req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0, req_b = '0;
  logic                  rsp_valid, rsp_ready = 1'b1, rsp_cout, rsp_ovf;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic [7:0]            add_a, add_b, add_s;
  logic                  add_cin, add_cout;
  logic                  hold_mode = 1'b0;
  logic [NREQ-1:0]       fired;
  int                    total = 0, bad = 0;

  cla8_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout)
  );

  // behavioural CLA8 slice
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_res(input logic [15:0] a, input logic [15:0] b, input bit sub,
                                  output logic [15:0] s, output bit c, output bit o);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin s = a - b; c = (a >= b);                     r = sa - sb; end
    else     begin s = a + b; c = (32'(a) + 32'(b)) > 32'hFFFF; r = sa + sb; end
    o = (r > 32767) || (r < -32768);
  endfunction

  // carry into byte k, from the low-order bits only
  function automatic bit ref_cin(input logic [15:0] a, input logic [15:0] b, input bit sub, input int k);
    logic [31:0] lo, al, bl;
    lo = (32'd1 << (8 * k)) - 32'd1;
    al = 32'(a) & lo;
    bl = 32'(b) & lo;
    return sub ? (al >= bl) : ((al + bl) > lo);
  endfunction

  // reference model, advanced once per cycle at the negedge
  bit          m_act;
  int          m_k, m_ptr, g;
  logic [15:0] m_a, m_b, e_sum, bb;
  bit          m_sub, e_c, e_o;
  logic [1:0]  m_id, last_id;
  logic [15:0] last_sum;
  logic        last_cout, last_ovf;

  always @(negedge clk) begin
    if (rst) begin
      m_act = 0; m_k = 0; m_ptr = NREQ - 1;
      last_id = '0; last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
      chk("rst_all_zero", 32'(|{req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
                                add_a, add_b, add_cin}), 32'd0);
    end else if (!m_act || m_k < BYTES) begin
      chk("rsp_quiet", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf},
          {1'b0, last_id, last_sum, last_cout, last_ovf});
      if (!m_act) begin
        g = -1;
        for (int i = 1; i <= NREQ; i++)
          if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
        chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
        chk("add_idle", {add_a, add_b, add_cin}, 0);
        if (g >= 0) begin
          m_a = req_a[g*WIDTH +: WIDTH];
          m_b = req_b[g*WIDTH +: WIDTH];
          m_sub = req_sub[g];
          m_id = 2'(g); m_ptr = g; m_act = 1; m_k = 0;
        end
      end else begin
        bb = (m_sub ? ~m_b : m_b) >> (8 * m_k);
        chk("run_ready", req_ready, 0);
        chk("run_add_a", add_a, 32'((m_a >> (8 * m_k)) & 16'hFF));
        chk("run_add_b", add_b, bb[7:0]);
        chk("run_add_cin", add_cin, ref_cin(m_a, m_b, m_sub, m_k));
        m_k++;
      end
    end else begin
      ref_res(m_a, m_b, m_sub, e_sum, e_c, e_o);
      chk("done_rsp", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, {1'b1, m_id, e_sum, e_c, e_o});
      chk("done_ready", req_ready, 0);
      chk("done_add", {add_a, add_b, add_cin}, 0);
      last_id = m_id; last_sum = e_sum; last_cout = e_c; last_ovf = e_o;
      if (rsp_ready) m_act = 0;
    end
  end

  // requesters drop valid once accepted, unless re-requesting continuously
  always @(posedge clk) begin
    fired = req_valid & req_ready;
    #1;
    if (!hold_mode) req_valid = req_valid & ~fired;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input bit sub);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_sub[i]   = sub;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int id, input logic [15:0] s, input bit c, input bit o);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    total++;
    if (!rsp_valid) begin
      bad++;
      $display("FAIL rsp_timeout waiting for id=%0d exp_sum=%h", id, s);
    end else if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {2'(id), s, c, o}) begin
      bad++;
      $display("FAIL rsp_value act id=%0d sum=%h c=%0b o=%0b exp id=%0d sum=%h c=%0b o=%0b",
               rsp_id, rsp_sum, rsp_cout, rsp_ovf, id, s, c, o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_sum", rsp_sum, 0);
    tick(); rst = 1'b0;

    // 0x12FF + 0x0001: cycle-by-cycle
    issue(0, 16'h12FF, 16'h0001, 0);
    @(negedge clk); chk("t0_ready", req_ready, 4'b0001);
    @(negedge clk); chk("b0_add_a", add_a, 8'hFF); chk("b0_cin", add_cin, 0);
    @(negedge clk); chk("b1_add_a", add_a, 8'h12); chk("b1_cin", add_cin, 1);
    @(negedge clk);
    chk("t3_valid", rsp_valid, 1);
    chk("t3_sum", rsp_sum, 16'h1300);
    chk("t3_flags", {rsp_id, rsp_cout, rsp_ovf}, 4'b0000);

    tick(); issue(1, 16'h0005, 16'h0007, 1);
    @(negedge clk); @(negedge clk);
    chk("sub_b0_b", add_b, 8'hF8);
    chk("sub_b0_cin", add_cin, 1);
    wait_rsp(1, 16'hFFFE, 0, 0);
    tick(); issue(2, 16'h8000, 16'h0001, 1); wait_rsp(2, 16'h7FFF, 1, 1);
    tick(); issue(0, 16'hFFFF, 16'h0001, 0); wait_rsp(0, 16'h0000, 1, 0);
    tick(); issue(3, 16'h7FFF, 16'h0001, 0); wait_rsp(3, 16'h8000, 0, 1);

    // continuous requests from everyone: strict rotation
    tick(); hold_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) issue(i, 16'(16'h1000 * (i + 1)), 16'(16'h0011 * (i + 1)), 0);
    wait_rsp(0, 16'h1011, 0, 0);
    wait_rsp(1, 16'h2022, 0, 0);
    wait_rsp(2, 16'h3033, 0, 0);
    wait_rsp(3, 16'h4044, 0, 0);
    wait_rsp(0, 16'h1011, 0, 0);
    #1 req_valid = 4'b1010;
    wait_rsp(1, 16'h2022, 0, 0);
    wait_rsp(3, 16'h4044, 0, 0);
    wait_rsp(1, 16'h2022, 0, 0);
    #1 req_valid = '0; hold_mode = 1'b0;

    // consumer stall in DONE
    tick(); rsp_ready = 1'b0; issue(2, 16'h1234, 16'h1111, 0);
    wait_rsp(2, 16'h2345, 0, 0);
    #1 issue(0, 16'h00FF, 16'h0F01, 0);
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_sum", rsp_sum, 16'h2345);
      chk("stall_ready", req_ready, 0);
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("resume_valid", rsp_valid, 0);
    chk("resume_ready", req_ready, 4'b0001);
    wait_rsp(0, 16'h1000, 0, 0);

    // async reset in RUN byte 1
    tick(); issue(1, 16'h0A01, 16'h0202, 0);
    @(negedge clk); chk("pre_rst_ready", req_ready, 4'b0010);
    @(posedge clk); @(posedge clk); #1;
    chk("pre_rst_b1_a", add_a, 8'h0A);
    rst = 1'b1;
    #1;
    chk("arst_outputs", 32'(|{req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
                              add_a, add_b, add_cin}), 0);
    issue(0, 16'h0003, 16'h0004, 0);
    issue(2, 16'h0010, 16'h0001, 1);
    repeat (2) @(negedge clk);
    chk("rst_hold_ready", req_ready, 0);
    tick(); rst = 1'b0;
    wait_rsp(0, 16'h0007, 0, 0);
    wait_rsp(2, 16'h000F, 1, 0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
